conv_seq_2x2: RTL and testbench

CONV_SEQ_2X2 -- requirements
Module: conv_seq_2x2

---
 rtl/conv_seq_2x2_if.sv | 29 ++
 rtl/conv_seq_2x2.sv | 192 +++++++++++++++++++
 tb/tb_conv_seq_2x2.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_2x2_if.sv
// Bus between the convolution sequencer and a 2x2 systolic array.
interface conv_seq_2x2_if;
    // Protocol: the sequencer pulses sa_weight_load for one cycle with the lane
    // weights on sa_w_in1/2. The array latches them on that edge. Each later
    // cycle, the activations on sa_act_in1/2 produce
    // sa_psum_outN = w_latchedN * act_inN (mod 256) exactly SA_LAT cycles
    // later. There is no backpressure, and the result is always taken.
    logic       sa_weight_load;
    logic [7:0] sa_w_in1;
    logic [7:0] sa_w_in2;
    logic [7:0] sa_act_in1;
    logic [7:0] sa_act_in2;
    logic [7:0] sa_psum_in1;
    logic [7:0] sa_psum_in2;
    logic [7:0] sa_psum_out1;
    logic [7:0] sa_psum_out2;

    modport master (
        output sa_weight_load, sa_w_in1, sa_w_in2, sa_act_in1, sa_act_in2,
               sa_psum_in1, sa_psum_in2,
        input  sa_psum_out1, sa_psum_out2
    );

    modport slave (
        input  sa_weight_load, sa_w_in1, sa_w_in2, sa_act_in1, sa_act_in2,
               sa_psum_in1, sa_psum_in2,
        output sa_psum_out1, sa_psum_out2
    );
endinterface

// File: rtl/conv_seq_2x2.sv
// Sequencer that computes a 3x3 kernel over a 4x4 map (2x2 valid outputs).
// It uses a two-lane systolic array. Each of 5 passes loads two kernel taps
// and then streams the four matching activations.
module conv_seq_2x2 #(
    parameter int SA_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [71:0]    w_flat,
    input  logic [127:0]   in_flat,
    output logic           busy,
    output logic           done,
    output logic [7:0]     conv_out_11,
    output logic [7:0]     conv_out_12,
    output logic [7:0]     conv_out_21,
    output logic [7:0]     conv_out_22,
    output logic [2:0]     dbg_state,
    conv_seq_2x2_if.master sa
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADW  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(SA_LAT - 1);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   cnt_q;       // stream position in STREAM, drain cycle in DRAIN
    logic [2:0]   pass_q;      // 0..4
    logic [71:0]  w_q;
    logic [127:0] in_q;
    logic [7:0]   acc [4];
    logic [7:0]   acc_nxt [4];
    logic [SA_LAT-1:0] tag_v;
    logic [1:0]   tag_p [SA_LAT];
    logic         accept;
    logic [3:0]   tap1;
    logic [3:0]   tap2;
    logic         lane2_on;

    // Activation for kernel tap 'tap' at output position p (order 11,12,21,22).
    function automatic logic [7:0] tap_act(input logic [3:0] tap,
                                           input logic [1:0] p,
                                           input logic [127:0] img);
        logic [3:0] rc;
        logic [1:0] row;
        logic [1:0] col;
        case (tap)
            4'd0:    rc = 4'b00_00;
            4'd1:    rc = 4'b00_01;
            4'd2:    rc = 4'b00_10;
            4'd3:    rc = 4'b01_00;
            4'd4:    rc = 4'b01_01;
            4'd5:    rc = 4'b01_10;
            4'd6:    rc = 4'b10_00;
            4'd7:    rc = 4'b10_01;
            4'd8:    rc = 4'b10_10;
            default: rc = 4'b00_00;
        endcase
        row = rc[3:2] + {1'b0, p[1]};
        col = rc[1:0] + {1'b0, p[0]};
        return img[{row, col, 3'b000} +: 8];
    endfunction

    assign accept    = (state == IDLE) && start;
    assign tap1      = {pass_q, 1'b0};
    assign tap2      = {pass_q, 1'b1};
    assign lane2_on  = (pass_q != 3'd4);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all combinational outputs, including the array drive.
    always_comb begin
        state_nxt         = state;
        busy              = 1'b0;
        done              = 1'b0;
        sa.sa_weight_load = 1'b0;
        sa.sa_w_in1       = 8'd0;
        sa.sa_w_in2       = 8'd0;
        sa.sa_act_in1     = 8'd0;
        sa.sa_act_in2     = 8'd0;
        sa.sa_psum_in1    = 8'd0;
        sa.sa_psum_in2    = 8'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOADW;
            end
            LOADW: begin
                busy              = 1'b1;
                sa.sa_weight_load = 1'b1;
                sa.sa_w_in1       = w_q[{tap1, 3'b000} +: 8];
                sa.sa_w_in2       = lane2_on ? w_q[{tap2, 3'b000} +: 8] : 8'd0;
                state_nxt         = STREAM;
            end
            STREAM: begin
                busy          = 1'b1;
                sa.sa_act_in1 = tap_act(tap1, cnt_q, in_q);
                sa.sa_act_in2 = lane2_on ? tap_act(tap2, cnt_q, in_q) : 8'd0;
                if (cnt_q == 2'd3) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt_q == DRAIN_LAST) state_nxt = (pass_q == 3'd4) ? FINISH : LOADW;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state cycle counter and pass number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            pass_q <= 3'd0;
        end else begin
            cnt_q <= (state_nxt != state) ? 2'd0 : cnt_q + 2'd1;
            if (accept) begin
                pass_q <= 3'd0;
            end else if (state == DRAIN && state_nxt == LOADW) begin
                pass_q <= pass_q + 3'd1;
            end
        end
    end

    // Operand capture on the accepting edge, so input changes while busy are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q  <= '0;
            in_q <= '0;
        end else if (accept) begin
            w_q  <= w_flat;
            in_q <= in_flat;
        end
    end

    // Add the lane results of the tag now leaving the pipeline into its output slot.
    always_comb begin
        for (int k = 0; k < 4; k++) acc_nxt[k] = acc[k];
        if (tag_v[SA_LAT-1]) begin
            acc_nxt[tag_p[SA_LAT-1]] = acc[tag_p[SA_LAT-1]] + sa.sa_psum_out1 + sa.sa_psum_out2;
        end
    end

    // Tag each STREAM cycle so its result lands in the right accumulator SA_LAT cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < SA_LAT; i++) tag_p[i] <= 2'd0;
            for (int k = 0; k < 4; k++) acc[k] <= 8'd0;
        end else begin
            tag_v[0] <= (state == STREAM);
            tag_p[0] <= cnt_q;
            for (int i = 1; i < SA_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_p[i] <= tag_p[i-1];
            end
            for (int k = 0; k < 4; k++) acc[k] <= accept ? 8'd0 : acc_nxt[k];
        end
    end

    // The last tag emerges on the edge that enters FINISH, so the results are
    // loaded from acc_nxt on that edge and are already visible while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_out_11 <= 8'd0;
            conv_out_12 <= 8'd0;
            conv_out_21 <= 8'd0;
            conv_out_22 <= 8'd0;
        end else if (state_nxt == FINISH) begin
            conv_out_11 <= acc_nxt[0];
            conv_out_12 <= acc_nxt[1];
            conv_out_21 <= acc_nxt[2];
            conv_out_22 <= acc_nxt[3];
        end
    end
endmodule

// File: tb/tb_conv_seq_2x2.sv
// Bench for conv_seq_2x2. It runs three instances (SA_LAT = 2, 1, 4) on shared
// stimulus, each with its own behavioural array and reference model.
module tb_conv_seq_2x2;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [71:0]  w_flat = '0;
    logic [127:0] in_flat = '0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           nd0 [3];
    int           nwl0 [3];

    // Clock generation and cycle count.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference 2x2 valid convolution, with plain modulo-256 arithmetic.
    function automatic logic [31:0] conv_ref(input logic [71:0] w, input logic [127:0] x);
        logic [31:0] res;
        int s;
        res = '0;
        for (int p = 0; p < 4; p++) begin
            s = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += int'(w[8*(3*r+c) +: 8]) * int'(x[8*(4*(p/2+r)+(p%2)+c) +: 8]);
            res[8*p +: 8] = 8'(s);
        end
        return res;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        localparam int P = 5 + L;
        localparam int D = 5 * P;

        conv_seq_2x2_if ifc ();
        logic        busy;
        logic        done;
        logic [7:0]  o11, o12, o21, o22;
        logic [2:0]  dbg_state;
        logic [31:0] outs;
        assign outs = {o22, o21, o12, o11};

        conv_seq_2x2 #(.SA_LAT(L)) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .w_flat      (w_flat),
            .in_flat     (in_flat),
            .busy        (busy),
            .done        (done),
            .conv_out_11 (o11),
            .conv_out_12 (o12),
            .conv_out_21 (o21),
            .conv_out_22 (o22),
            .dbg_state   (dbg_state),
            .sa          (ifc)
        );

        // Behavioural array: latch weights, product appears L cycles after the activation.
        logic [7:0] wl1 = '0, wl2 = '0;
        logic [7:0] pipe1 [L];
        logic [7:0] pipe2 [L];
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                wl1 <= '0;
                wl2 <= '0;
                for (int i = 0; i < L; i++) begin
                    pipe1[i] <= '0;
                    pipe2[i] <= '0;
                end
            end else begin
                if (ifc.sa_weight_load) begin
                    wl1 <= ifc.sa_w_in1;
                    wl2 <= ifc.sa_w_in2;
                end
                pipe1[0] <= 8'(wl1 * ifc.sa_act_in1);
                pipe2[0] <= 8'(wl2 * ifc.sa_act_in2);
                for (int i = 1; i < L; i++) begin
                    pipe1[i] <= pipe1[i-1];
                    pipe2[i] <= pipe2[i-1];
                end
            end
        end
        assign ifc.sa_psum_out1 = pipe1[L-1];
        assign ifc.sa_psum_out2 = pipe2[L-1];

        // Reference model: cycles since acceptance, captured operands, expected held outputs.
        int           cnt = 0;
        int           start_cyc = 0;
        logic [71:0]  mw = '0;
        logic [127:0] mx = '0;
        logic [31:0]  exp_out = '0;
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= 0;
                exp_out <= '0;
            end else if (cnt == 0) begin
                if (start) begin
                    cnt       <= 1;
                    mw        <= w_flat;
                    mx        <= in_flat;
                    start_cyc <= cyc + 1;
                end
            end else if (cnt == D) begin
                cnt     <= D + 1;
                exp_out <= conv_ref(mw, mx);
            end else if (cnt == D + 1) begin
                cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end

        // Compare every cycle against the model; also log done/weight-load events.
        int         n_done = 0;
        int         done_lat = 0;
        int         n_wl = 0;
        logic [7:0] last_w2 = '0;
        always @(negedge clk) begin : cmp
            int n, o, t1, t2, oi, oj;
            logic eb, ed, ewl;
            logic [7:0] ew1, ew2, ea1, ea2;
            eb = (cnt >= 1) && (cnt <= D);
            ed = (cnt == D + 1);
            ewl = 1'b0; ew1 = '0; ew2 = '0; ea1 = '0; ea2 = '0;
            if (eb) begin
                n = (cnt - 1) / P;
                o = (cnt - 1) % P;
                t1 = 2 * n;
                t2 = 2 * n + 1;
                if (o == 0) begin
                    ewl = 1'b1;
                    ew1 = mw[8*t1 +: 8];
                    if (n < 4) ew2 = mw[8*t2 +: 8];
                end else if (o <= 4) begin
                    oi = (o - 1) / 2;
                    oj = (o - 1) % 2;
                    ea1 = mx[8*(4*(oi+t1/3)+oj+t1%3) +: 8];
                    if (n < 4) ea2 = mx[8*(4*(oi+t2/3)+oj+t2%3) +: 8];
                end
            end
            if (cyc > 0) begin
                check($sformatf("L%0d_busy", L), 32'(busy), 32'(eb));
                check($sformatf("L%0d_done", L), 32'(done), 32'(ed));
                check($sformatf("L%0d_outs", L), outs, exp_out);
                check($sformatf("L%0d_wload", L), 32'(ifc.sa_weight_load), 32'(ewl));
                if (ewl) begin
                    check($sformatf("L%0d_w_in1", L), 32'(ifc.sa_w_in1), 32'(ew1));
                    check($sformatf("L%0d_w_in2", L), 32'(ifc.sa_w_in2), 32'(ew2));
                end
                check($sformatf("L%0d_act1", L), 32'(ifc.sa_act_in1), 32'(ea1));
                check($sformatf("L%0d_act2", L), 32'(ifc.sa_act_in2), 32'(ea2));
                check($sformatf("L%0d_psum_in", L), {ifc.sa_psum_in2, ifc.sa_psum_in1}, 32'd0);
                if (done) begin
                    n_done++;
                    done_lat = cyc - start_cyc;
                end
                if (ifc.sa_weight_load) begin
                    n_wl++;
                    last_w2 = ifc.sa_w_in2;
                end
            end
        end
    end

    task automatic snap();
        nd0[0] = g_inst[0].n_done;  nwl0[0] = g_inst[0].n_wl;
        nd0[1] = g_inst[1].n_done;  nwl0[1] = g_inst[1].n_wl;
        nd0[2] = g_inst[2].n_done;  nwl0[2] = g_inst[2].n_wl;
    endtask

    task automatic check_inst(input string nm, input int lat_exp, input int dd, input int dwl,
                              input logic [7:0] w2, input int lat,
                              input logic [31:0] outs, input logic [31:0] e);
        check({nm, "_ndone"}, 32'(dd), 32'd1);
        check({nm, "_nwload"}, 32'(dwl), 32'd5);
        check({nm, "_pass4_w2"}, 32'(w2), 32'd0);
        check({nm, "_latency"}, 32'(lat), 32'(lat_exp));
        check({nm, "_result"}, outs, e);
    endtask

    task automatic check_op(input string nm, input logic [31:0] e);
        check_inst({nm, "_L2"}, 35, g_inst[0].n_done - nd0[0], g_inst[0].n_wl - nwl0[0],
                   g_inst[0].last_w2, g_inst[0].done_lat, g_inst[0].outs, e);
        check_inst({nm, "_L1"}, 30, g_inst[1].n_done - nd0[1], g_inst[1].n_wl - nwl0[1],
                   g_inst[1].last_w2, g_inst[1].done_lat, g_inst[1].outs, e);
        check_inst({nm, "_L4"}, 45, g_inst[2].n_done - nd0[2], g_inst[2].n_wl - nwl0[2],
                   g_inst[2].last_w2, g_inst[2].done_lat, g_inst[2].outs, e);
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_busy"}, 32'({g_inst[2].busy, g_inst[1].busy, g_inst[0].busy}), 32'd0);
        check({nm, "_done"}, 32'({g_inst[2].done, g_inst[1].done, g_inst[0].done}), 32'd0);
        check({nm, "_outs_L2"}, g_inst[0].outs, 32'd0);
        check({nm, "_outs_L1"}, g_inst[1].outs, 32'd0);
        check({nm, "_outs_L4"}, g_inst[2].outs, 32'd0);
        check({nm, "_sa_L2"}, {g_inst[0].ifc.sa_act_in1, g_inst[0].ifc.sa_act_in2,
                               g_inst[0].ifc.sa_w_in1, 7'd0, g_inst[0].ifc.sa_weight_load}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [71:0] w, input logic [127:0] x);
        snap();
        w_flat  = w;
        in_flat = x;
        pulse_start();
        repeat (55) @(posedge clk);
        #2;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin : main
        logic [71:0]  w_ones, w_16, w_tap4, w_mix;
        logic [127:0] x_ones, x_2, x_ij, x_mix;
        w_ones = {9{8'd1}};
        w_16   = {9{8'd16}};
        w_tap4 = 72'd1 << 32;
        x_ones = {16{8'd1}};
        x_2    = {16{8'd2}};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                x_ij[8*(4*i+j) +: 8]  = 8'(10 * i + j);
                x_mix[8*(4*i+j) +: 8] = 8'(37 * (4*i+j) + 5);
            end
        for (int k = 0; k < 9; k++) w_mix[8*k +: 8] = 8'(29 * k + 3);

        // Held in reset for a few cycles.
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #2;

        run_op(w_ones, x_ones);
        check_op("ones", 32'h09090909);
        run_op(w_tap4, x_ij);
        check_op("tap4", 32'h16150c0b);
        run_op(w_16, x_2);
        check_op("wrap", 32'h20202020);

        // Extra start pulses with new operands while busy must change nothing.
        snap();
        w_flat  = w_ones;
        in_flat = x_ones;
        pulse_start();
        w_flat  = w_16;
        in_flat = x_2;
        repeat (3) @(posedge clk);
        #2;
        pulse_start();
        repeat (14) @(posedge clk);
        #2;
        pulse_start();
        repeat (40) @(posedge clk);
        #2;
        check_op("repulse", 32'h09090909);
        run_op(w_tap4, x_ij);
        check_op("after_repulse", 32'h16150c0b);

        // Reset in the middle of an operation.
        snap();
        w_flat  = w_ones;
        in_flat = x_ones;
        pulse_start();
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check_idle("abort");
        repeat (50) @(posedge clk);
        #2;
        check("abort_nodone_L2", 32'(g_inst[0].n_done - nd0[0]), 32'd0);
        check("abort_nodone_L1", 32'(g_inst[1].n_done - nd0[1]), 32'd0);
        check("abort_nodone_L4", 32'(g_inst[2].n_done - nd0[2]), 32'd0);
        run_op(w_ones, x_ones);
        check_op("after_abort", 32'h09090909);

        run_op(w_mix, x_mix);
        check_op("mixed", conv_ref(w_mix, x_mix));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
